// File: rtl/pipe_pkg.sv
// Shared pipeline types: the EX/MEM bundle layout, skid-buffer states and the
// ResultSrc encodings used by the writeback mux.
package pipe_pkg;

  // Bundle fields are sized for the widest supported datapath; narrower stages
  // zero-extend on entry and truncate on exit.
  localparam int EM_DATA_MAX = 64;
  localparam int EM_REG_MAX  = 8;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_write;
    logic [1:0]             result_src;
    logic [EM_DATA_MAX-1:0] alu_result;
    logic [EM_DATA_MAX-1:0] write_data;
    logic [EM_DATA_MAX-1:0] pc_plus4;
    logic [EM_REG_MAX-1:0]  rd;
  } em_bundle_t;

endpackage

// File: rtl/pipe_skid.sv
// Generic valid/ready pipeline register: a two-entry skid buffer with a fully
// registered ready, or a single register with a combinational ready path.
module pipe_skid
  import pipe_pkg::*;
#(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  generate
    if (SKID_EN) begin : g_skid
      skid_state_t  state_reg;
      skid_state_t  state_next;
      logic         ready_reg;
      logic [W-1:0] out_reg;
      logic [W-1:0] skid_reg;
      logic         load_out_in;
      logic         load_out_skid;
      logic         load_skid;

      always_comb begin
        state_next    = state_reg;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_reg)
          SKID_EMPTY: begin
            if (in_fire) begin
              state_next  = SKID_ONE;
              load_out_in = 1'b1;
            end
          end
          SKID_ONE: begin
            if (in_fire && out_fire) begin
              load_out_in = 1'b1;
            end else if (in_fire) begin
              state_next = SKID_FULL;
              load_skid  = 1'b1;
            end else if (out_fire) begin
              state_next = SKID_EMPTY;
            end
          end
          SKID_FULL: begin
            if (out_fire) begin
              state_next    = SKID_ONE;
              load_out_skid = 1'b1;
            end
          end
          default: state_next = SKID_EMPTY;
        endcase
        // Flush overrides every transfer; the output register keeps its old
        // contents so data outputs hold while the stage is empty.
        if (flush) begin
          state_next    = SKID_EMPTY;
          load_out_in   = 1'b0;
          load_out_skid = 1'b0;
          load_skid     = 1'b0;
        end
      end

      // ready is computed from the next state so it never depends on out_ready
      // within the same cycle; it stays low until the first edge after reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= SKID_EMPTY;
          ready_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          ready_reg <= (state_next != SKID_FULL);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_reg  <= '0;
          skid_reg <= '0;
        end else begin
          if (load_out_in) begin
            out_reg <= in_data;
          end else if (load_out_skid) begin
            out_reg <= skid_reg;
          end
          if (load_skid) begin
            skid_reg <= in_data;
          end
        end
      end

      assign in_ready  = ready_reg;
      assign out_valid = (state_reg != SKID_EMPTY);
      assign out_data  = out_reg;
    end else begin : g_reg
      logic         valid_reg;
      logic         en_reg;
      logic [W-1:0] data_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          en_reg    <= 1'b0;
          data_reg  <= '0;
        end else begin
          en_reg <= 1'b1;
          if (flush) begin
            valid_reg <= 1'b0;
          end else if (in_fire) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
          end else if (out_fire) begin
            valid_reg <= 1'b0;
          end
        end
      end

      // en_reg keeps ready low while reset is held even though the stage is empty.
      assign in_ready  = en_reg && (out_ready || !valid_reg);
      assign out_valid = valid_reg;
      assign out_data  = data_reg;
    end
  endgenerate

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline boundary: packs the execute-stage bundle into em_bundle_t,
// buffers it in pipe_skid and presents the memory-stage view with bubbles.
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit SKID_EN        = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      ValidE,
  output logic                      ReadyE,
  input  logic                      RegWriteE,
  input  logic                      MemWriteE,
  input  logic [1:0]                ResultSrcE,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     WriteDataE,
  input  logic [DATA_WIDTH-1:0]     PCPlus4E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ValidM,
  input  logic                      ReadyM,
  output logic                      RegWriteM,
  output logic                      MemWriteM,
  output logic [1:0]                ResultSrcM,
  output logic [DATA_WIDTH-1:0]     ALUResultM,
  output logic [DATA_WIDTH-1:0]     WriteDataM,
  output logic [DATA_WIDTH-1:0]     PCPlus4M,
  output logic [REG_ADDR_WIDTH-1:0] RdM
);

  localparam int PAY_W = $bits(em_bundle_t);

  em_bundle_t bundle_in;
  em_bundle_t bundle_out;
  logic       valid_m;

  always_comb begin
    bundle_in            = '0;
    bundle_in.reg_write  = RegWriteE;
    bundle_in.mem_write  = MemWriteE;
    bundle_in.result_src = ResultSrcE;
    bundle_in.alu_result = EM_DATA_MAX'(ALUResult);
    bundle_in.write_data = EM_DATA_MAX'(WriteDataE);
    bundle_in.pc_plus4   = EM_DATA_MAX'(PCPlus4E);
    bundle_in.rd         = EM_REG_MAX'(RdE);
  end

  pipe_skid #(
    .W       (PAY_W),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ValidE),
    .in_ready  (ReadyE),
    .in_data   (bundle_in),
    .out_valid (valid_m),
    .out_ready (ReadyM),
    .out_data  (bundle_out)
  );

  // Only the side-effecting control bits are squashed on a bubble; payload holds.
  always_comb begin
    ValidM     = valid_m;
    RegWriteM  = valid_m && bundle_out.reg_write;
    MemWriteM  = valid_m && bundle_out.mem_write;
    ResultSrcM = bundle_out.result_src;
    ALUResultM = DATA_WIDTH'(bundle_out.alu_result);
    WriteDataM = DATA_WIDTH'(bundle_out.write_data);
    PCPlus4M   = DATA_WIDTH'(bundle_out.pc_plus4);
    RdM        = REG_ADDR_WIDTH'(bundle_out.rd);
  end

endmodule

// File: doc/ex_mem_skid_stage.md
EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of ALUResult, WriteData and PCPlus4 payload fields.
REQ-002 Parameter REG_ADDR_WIDTH, default 5: width of destination register index Rd.
REQ-003 Parameter SKID_EN, default 1: 1 selects a two-entry skid buffer; 0 selects a single register with a combinational ready path.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 ValidE  input  1  upstream holds a valid EX-stage bundle.
REQ-008 ReadyE  output  1  stage can accept a bundle this cycle.
REQ-009 RegWriteE, MemWriteE  input  1 each  control bits.
REQ-010 ResultSrcE  input  2  result-mux select.
REQ-011 ALUResult, WriteDataE, PCPlus4E  input  DATA_WIDTH each  datapath payload.
REQ-012 RdE  input  REG_ADDR_WIDTH  destination register.
REQ-013 ValidM  output  1  output bundle is valid.
REQ-014 ReadyM  input  1  downstream accepts the output bundle this cycle.
REQ-015 RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM  output  widths matching their E counterparts  registered bundle.

Function
REQ-016 A bundle SHALL transfer in when ValidE && ReadyE, and transfer out when ValidM && ReadyM.
REQ-017 In SKID_EN=1, the stage SHALL implement three states: EMPTY (no entry), ONE (output register valid), FULL (output register and skid register valid).
REQ-018 State transitions SHALL be:
- EMPTY + in -> ONE.
- ONE + in, no out -> FULL, with the bundle captured in the skid register.
- ONE + out, no in -> EMPTY.
- ONE + in + out -> ONE, with the output register reloaded.
- FULL + out -> ONE, with the skid register moved to the output register.
REQ-019 In SKID_EN=1, ReadyE SHALL be a registered signal: 1 in EMPTY and ONE, 0 in FULL, with no combinational path from ReadyM.
REQ-020 In SKID_EN=0, ReadyE SHALL equal ReadyM || !ValidM, and the single register SHALL load on every input transfer.
REQ-021 Latency from input transfer to ValidM SHALL be one cycle when the stage is empty.
REQ-022 Ordering SHALL be strict FIFO; no bundle SHALL be dropped or duplicated except by flush or reset.
REQ-023 While ValidM=0, RegWriteM and MemWriteM SHALL be driven 0 (bubble), and the data outputs SHALL hold their last values.
REQ-024 Output fields SHALL be stable while ValidM && !ReadyM.
REQ-025 flush SHALL empty all entries at the next edge (ValidM=0, state EMPTY, ReadyE=1 the following cycle), taking priority over any simultaneous input or output transfer; a bundle presented in the flush cycle is discarded.
REQ-026 ValidE=0 with ReadyE=1 SHALL leave the state unchanged apart from any output transfer.

Reset
REQ-027 Asserting rst SHALL immediately force state EMPTY, ValidM=0 and every M output to 0, independent of clk.
REQ-028 ReadyE SHALL be 0 while rst is high and 1 on the first cycle after deassertion.
REQ-029 Reset asserted mid-transfer SHALL discard all held bundles.

Structure
REQ-030 A shared package pipe_pkg SHALL hold:
- the em_bundle_t packed struct (all E/M payload fields);
- the skid state enum;
- the ResultSrc encoding constants (ALU, MEM, PC4).
REQ-031 A generic sub-module pipe_skid SHALL hold the handshake and state logic, parametrised on payload width and SKID_EN.
REQ-032 ex_mem_skid_stage SHALL pack and unpack em_bundle_t around the pipe_skid instance.

Verification
REQ-033 Reset: assert rst mid-stream with two bundles held -> ValidM=0, all outputs 0, ReadyE=1 one cycle after release.
REQ-034 Stream: ReadyM=1, send ALUResult=0x10,0x20,0x30 on consecutive cycles -> ALUResultM shows the same sequence, each exactly one cycle later.
REQ-035 Backpressure: ReadyM=0, send 0xA then 0xB -> state FULL, ReadyE=0, ALUResultM=0xA held; raise ReadyM -> 0xA then 0xB out, no loss.
REQ-036 Flush: FULL with 0xA/0xB, assert flush with ValidE=1 carrying 0xC -> next cycle ValidM=0, MemWriteM=0, RegWriteM=0; 0xC never appears.
REQ-037 Bubble: ValidE=1 with MemWriteE=1 for one cycle, then ValidE=0 -> MemWriteM=1 for exactly one cycle.
REQ-038 SKID_EN=0: ReadyM=0 with ValidM=1 -> ReadyE=0 in the same cycle; ReadyM=1 -> simultaneous in/out every cycle.
